// File: rtl/ahb3lite_bus_arbiter_if.sv
// Bundle of the two master-side AHB-Lite ports and the shared slave-side bus.
// The arbiter uses the "master" modport, because it drives the slave bus. The environment uses the "slave" modport.
interface ahb3lite_bus_arbiter_if;
    logic        HBUSREQ_M0;
    logic        HBUSREQ_M1;
    logic        HGRANT_M0;
    logic        HGRANT_M1;
    logic [31:0] HADDR_M0;
    logic [31:0] HADDR_M1;
    logic [31:0] HWDATA_M0;
    logic [31:0] HWDATA_M1;
    logic        HWRITE_M0;
    logic        HWRITE_M1;
    logic [2:0]  HBURST_M0;
    logic [2:0]  HBURST_M1;
    logic [2:0]  HSIZE_M0;
    logic [2:0]  HSIZE_M1;
    logic [1:0]  HTRANS_M0;
    logic [1:0]  HTRANS_M1;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic        HRESP;
    logic        HMASTER;

    modport master (
        input  HBUSREQ_M0, HBUSREQ_M1,
        input  HADDR_M0, HADDR_M1, HWDATA_M0, HWDATA_M1,
        input  HWRITE_M0, HWRITE_M1, HBURST_M0, HBURST_M1,
        input  HSIZE_M0, HSIZE_M1, HTRANS_M0, HTRANS_M1,
        input  HREADY, HRESP,
        output HGRANT_M0, HGRANT_M1,
        output HADDR, HWDATA, HWRITE, HBURST, HSIZE, HTRANS, HMASTER
    );

    modport slave (
        output HBUSREQ_M0, HBUSREQ_M1,
        output HADDR_M0, HADDR_M1, HWDATA_M0, HWDATA_M1,
        output HWRITE_M0, HWRITE_M1, HBURST_M0, HBURST_M1,
        output HSIZE_M0, HSIZE_M1, HTRANS_M0, HTRANS_M1,
        output HREADY, HRESP,
        input  HGRANT_M0, HGRANT_M1,
        input  HADDR, HWDATA, HWRITE, HBURST, HSIZE, HTRANS, HMASTER
    );
endinterface

// File: rtl/ahb3lite_bus_arbiter.sv
// Two-master AHB-Lite arbiter: round-robin grant on burst boundaries, address mux by grant,
// write-data mux by data-phase owner, bus parked on master 0.
module ahb3lite_bus_arbiter #(
    parameter int unsigned INCR_LIMIT = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb3lite_bus_arbiter_if.master bus
);
    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;
    localparam logic [5:0] LIMIT_W   = 6'(INCR_LIMIT);

    logic       gnt_r;
    logic       data_owner_r;
    logic [4:0] beat_cnt_r;
    logic       gnt_nxt_s;
    logic       data_owner_nxt_s;
    logic [4:0] beat_cnt_nxt_s;
    logic [1:0] own_trans_s;
    logic [2:0] own_burst_s;
    logic       own_req_s;
    logic       other_req_s;
    logic [5:0] cur_beat_s;
    logic [5:0] burst_len_s;
    logic       boundary_s;

    // A return value of 0 stands for an undefined-length INCR burst.
    function automatic logic [5:0] burst_len(input logic [2:0] hburst);
        logic [5:0] len;
        case (hburst)
            3'd0:       len = 6'd1;
            3'd2, 3'd3: len = 6'd4;
            3'd4, 3'd5: len = 6'd8;
            3'd6, 3'd7: len = 6'd16;
            default:    len = 6'd0;
        endcase
        return len;
    endfunction

    // State register: grant, data-phase owner and beat counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gnt_r        <= 1'b0;
            data_owner_r <= 1'b0;
            beat_cnt_r   <= 5'd0;
        end else begin
            gnt_r        <= gnt_nxt_s;
            data_owner_r <= data_owner_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
        end
    end

    // Next-state logic: detect the burst boundary and choose the next owner.
    always_comb begin
        if (gnt_r) begin
            own_trans_s = bus.HTRANS_M1;
            own_burst_s = bus.HBURST_M1;
            own_req_s   = bus.HBUSREQ_M1;
            other_req_s = bus.HBUSREQ_M0;
        end else begin
            own_trans_s = bus.HTRANS_M0;
            own_burst_s = bus.HBURST_M0;
            own_req_s   = bus.HBUSREQ_M0;
            other_req_s = bus.HBUSREQ_M1;
        end

        burst_len_s = burst_len(own_burst_s);
        // A NONSEQ beat is always beat 1, whatever count remains from an earlier burst.
        cur_beat_s  = (own_trans_s == TR_NONSEQ) ? 6'd1 : ({1'b0, beat_cnt_r} + 6'd1);

        boundary_s = 1'b0;
        if (bus.HREADY) begin
            case (own_trans_s)
                TR_IDLE: boundary_s = 1'b1;
                TR_BUSY: boundary_s = 1'b0;
                TR_NONSEQ, TR_SEQ: begin
                    if (burst_len_s != 6'd0) begin
                        boundary_s = bus.HRESP || (cur_beat_s == burst_len_s);
                    end else begin
                        boundary_s = bus.HRESP || !own_req_s ||
                                     ((cur_beat_s >= LIMIT_W) && other_req_s);
                    end
                end
                default: boundary_s = 1'b0;
            endcase
        end else begin
            boundary_s = 1'b0;
        end

        if (boundary_s) begin
            if (other_req_s) begin
                gnt_nxt_s = ~gnt_r;
            end else if (own_req_s) begin
                gnt_nxt_s = gnt_r;
            end else begin
                gnt_nxt_s = 1'b0;
            end
        end else begin
            gnt_nxt_s = gnt_r;
        end

        if (bus.HREADY) begin
            data_owner_nxt_s = gnt_r;
            if (gnt_nxt_s != gnt_r) begin
                beat_cnt_nxt_s = 5'd0;
            end else begin
                case (own_trans_s)
                    TR_NONSEQ: beat_cnt_nxt_s = 5'd1;
                    TR_SEQ:    beat_cnt_nxt_s = (beat_cnt_r == 5'd31) ? 5'd31 : beat_cnt_r + 5'd1;
                    TR_IDLE:   beat_cnt_nxt_s = 5'd0;
                    default:   beat_cnt_nxt_s = beat_cnt_r;
                endcase
            end
        end else begin
            data_owner_nxt_s = data_owner_r;
            beat_cnt_nxt_s   = beat_cnt_r;
        end
    end

    // Output logic: address-phase mux by grant, write data mux by data-phase owner.
    always_comb begin
        bus.HGRANT_M0 = ~gnt_r;
        bus.HGRANT_M1 = gnt_r;
        bus.HMASTER   = gnt_r;
        if (gnt_r) begin
            bus.HADDR  = bus.HADDR_M1;
            bus.HWRITE = bus.HWRITE_M1;
            bus.HBURST = bus.HBURST_M1;
            bus.HSIZE  = bus.HSIZE_M1;
            bus.HTRANS = bus.HTRANS_M1;
        end else begin
            bus.HADDR  = bus.HADDR_M0;
            bus.HWRITE = bus.HWRITE_M0;
            bus.HBURST = bus.HBURST_M0;
            bus.HSIZE  = bus.HSIZE_M0;
            bus.HTRANS = bus.HTRANS_M0;
        end
        if (data_owner_r) begin
            bus.HWDATA = bus.HWDATA_M1;
        end else begin
            bus.HWDATA = bus.HWDATA_M0;
        end
    end
endmodule
